vga_pixel_fetch: RTL and testbench

Upstream feeder for the 640x480 VGA controller: reads a double-buffered 12-bit RGB frame buffer written by the JPEG decoder and presents `pixel_data` already aligned to the 800x525 raster. It runs its own fetch counter ahead of the display position to hide memory read latency. It also performs a tear-free bank swap at frame boundaries via a ready/ack handshake with the writer.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_timing_counter.sv | 35 +++
 rtl/vga_pixel_fetch.sv | 181 ++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants: 640x480 @ 800x525 timing, RGB 4:4:4 pixel
// width, frame buffer size and the eight test-bar colours.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int PIX_W    = 12;
  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE;

  // Bar 0 is the leftmost: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][PIX_W-1:0] BAR_COLOURS = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster position counter with a configurable reset
// position. Used for both the fetch and the display positions.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL,
  parameter int H_RST = 0,
  parameter int V_RST = 0,
  parameter int HW    = $clog2(H_TOT),
  parameter int VW    = $clog2(V_TOT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  // Advance one pixel per clock, wrapping h at line end and v at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= HW'(H_RST);
      v <= VW'(V_RST);
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Frame-buffer reader for the VGA controller. A fetch position runs
// RD_LAT+1 clocks ahead of the display position so that read data lands in
// pixel_data exactly when the display reaches that pixel. Banks swap only at
// the last fetch position of a frame, so a displayed frame never mixes banks.
// Optional build macro: VGA_PIXEL_FETCH_TESTPAT_EN shows colour bars until
// the first frame has been committed.
module vga_pixel_fetch #(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = $clog2(vga_pkg::FB_WORDS),
  parameter int PIX_W  = vga_pkg::PIX_W,
  parameter int H_ACT  = vga_pkg::H_ACTIVE,
  parameter int H_TOT  = vga_pkg::H_TOTAL,
  parameter int V_ACT  = vga_pkg::V_ACTIVE,
  parameter int V_TOT  = vga_pkg::V_TOTAL
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_bank,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              frame_start,
  output logic              have_frame
);

  localparam int LEAD = RD_LAT + 1;
  localparam int HW   = $clog2(H_TOT);
  localparam int VW   = $clog2(V_TOT);

  localparam logic [HW-1:0] H_ACT_L = HW'(H_ACT);
  localparam logic [VW-1:0] V_ACT_L = VW'(V_ACT);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);

  logic [HW-1:0] fh;
  logic [VW-1:0] fv;
  logic [HW-1:0] dh;
  logic [VW-1:0] dv;

  logic fetch_vis;
  logic fetch_act;
  logic fetch_last;

  logic [RD_LAT-1:0] vld_p;
  logic [PIX_W-1:0]  pix_nxt;

  vga_timing_counter #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT),
    .H_RST (0),
    .V_RST (0),
    .HW    (HW),
    .VW    (VW)
  ) u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .h   (fh),
    .v   (fv)
  );

  // Display position starts LEAD clocks behind fetch (0,0).
  vga_timing_counter #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT),
    .H_RST (H_TOT - LEAD),
    .V_RST (V_TOT - 1),
    .HW    (HW),
    .VW    (VW)
  ) u_disp_cnt (
    .clk (clk),
    .rst (rst),
    .h   (dh),
    .v   (dv)
  );

  assign fetch_vis   = (fh < H_ACT_L) && (fv < V_ACT_L);
  assign fetch_act   = fetch_vis && have_frame;
  assign fetch_last  = (fh == H_LAST) && (fv == V_LAST);
  assign mem_rd_en   = fetch_act;
  assign frame_start = (dh == '0) && (dv == '0);

  // Linear address: advances on every issued read, back to zero for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
    end else if (fetch_last) begin
      mem_addr <= '0;
    end else if (fetch_act) begin
      mem_addr <= mem_addr + 1'b1;
    end
  end

  // Bank swap handshake, decided once per frame at the last fetch position.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_bank   <= 1'b0;
      have_frame <= 1'b0;
      frame_ack  <= 1'b0;
    end else begin
      frame_ack <= 1'b0;
      if (fetch_last && frame_ready) begin
        mem_bank   <= ~mem_bank;
        have_frame <= 1'b1;
        frame_ack  <= 1'b1;
      end
    end
  end

  // ---- read-latency pipeline: vld_p[RD_LAT-1] marks mem_rdata as a real read
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= fetch_act;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
  localparam int BAR_W = H_ACT / 8;

  logic [RD_LAT-1:0] bar_vld_p;
  logic [2:0]        bar_idx_p [RD_LAT];
  logic [2:0]        bar_sel;

  assign bar_sel = 3'(fh / HW'(BAR_W));

  // Bar flag travels with the read pipeline so bars line up with the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_vld_p <= '0;
    end else begin
      bar_vld_p[0] <= fetch_vis && !have_frame;
      for (int i = 1; i < RD_LAT; i++) begin
        bar_vld_p[i] <= bar_vld_p[i-1];
      end
    end
  end

  // Bar index rides alongside its flag; only meaningful when the flag is set.
  always_ff @(posedge clk) begin
    bar_idx_p[0] <= bar_sel;
    for (int i = 1; i < RD_LAT; i++) begin
      bar_idx_p[i] <= bar_idx_p[i-1];
    end
  end

  // Memory data wins; otherwise a bar colour or blank.
  always_comb begin
    pix_nxt = '0;
    if (vld_p[RD_LAT-1]) begin
      pix_nxt = mem_rdata;
    end else if (bar_vld_p[RD_LAT-1]) begin
      pix_nxt = PIX_W'(vga_pkg::BAR_COLOURS[bar_idx_p[RD_LAT-1]]);
    end
  end
`else
  // Memory data when a read is landing, blank otherwise.
  always_comb begin
    pix_nxt = '0;
    if (vld_p[RD_LAT-1]) begin
      pix_nxt = mem_rdata;
    end
  end
`endif

  // ---- output stage: pixel_data aligned to the display position
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_data <= '0;
    end else begin
      pixel_data <= pix_nxt;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch on a reduced 16x6 (20x8 total) raster with
// RD_LAT=2. A behavioural model derives every expected output from the cycle
// count since reset, the frame_ready history and a latency-accurate memory.
module tb_vga_pixel_fetch;

  localparam int RD_LAT = 2;
  localparam int LEAD   = RD_LAT + 1;
  localparam int H_ACT  = 16;
  localparam int H_TOT  = 20;
  localparam int V_ACT  = 6;
  localparam int V_TOT  = 8;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;
  localparam int HIST   = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_ready = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_bank;
  logic [PIX_W-1:0]  mem_rdata;
  logic              frame_ack;
  logic [PIX_W-1:0]  pixel_data;
  logic              frame_start;
  logic              have_frame;

  always #5 clk = ~clk;

  vga_pixel_fetch #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W),
    .H_ACT  (H_ACT),
    .H_TOT  (H_TOT),
    .V_ACT  (V_ACT),
    .V_TOT  (V_TOT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_bank    (mem_bank),
    .mem_rdata   (mem_rdata),
    .frame_ready (frame_ready),
    .frame_ack   (frame_ack),
    .pixel_data  (pixel_data),
    .frame_start (frame_start),
    .have_frame  (have_frame)
  );

  // Frame-buffer contents: bank 1 holds addr[11:0], bank 0 its complement.
  function automatic logic [PIX_W-1:0] memf(input logic bank, input int addr);
    logic [PIX_W-1:0] a;
    a = PIX_W'(addr);
    return bank ? a : ~a;
  endfunction

  // Memory with RD_LAT cycles of latency; random junk when no read lands.
  logic              q_en   [RD_LAT];
  logic [ADDR_W-1:0] q_addr [RD_LAT];
  logic              q_bank [RD_LAT];
  logic [PIX_W-1:0]  q_junk [RD_LAT];

  always @(posedge clk) begin
    q_en[0]   <= mem_rd_en;
    q_addr[0] <= mem_addr;
    q_bank[0] <= mem_bank;
    q_junk[0] <= PIX_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) begin
      q_en[i]   <= q_en[i-1];
      q_addr[i] <= q_addr[i-1];
      q_bank[i] <= q_bank[i-1];
      q_junk[i] <= q_junk[i-1];
    end
  end

  assign mem_rdata = (q_en[RD_LAT-1] === 1'b1) ?
                     memf(q_bank[RD_LAT-1], int'(q_addr[RD_LAT-1])) : q_junk[RD_LAT-1];

  // Reference model state
  int n;
  bit m_bank, m_have, m_ack;
  bit h_act  [HIST];
  bit h_bank [HIST];
  bit h_bar  [HIST];

  int tests = 0;
  int fails = 0;

  typedef struct {
    int               dh;
    int               dv;
    logic [PIX_W-1:0] pix;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, n, act, exp);
    end
  endtask

  function automatic int disp_h();
    return ((n + FRAME - LEAD) % FRAME) % H_TOT;
  endfunction

  function automatic int disp_v();
    return ((n + FRAME - LEAD) % FRAME) / H_TOT;
  endfunction

  task automatic check_all();
    int p, fh, fv, dh, dv, k;
    bit act;
    logic [PIX_W-1:0] exp_pix;
    p   = n % FRAME;
    fh  = p % H_TOT;
    fv  = p / H_TOT;
    act = (fh < H_ACT) && (fv < V_ACT);
    chk("mem_rd_en", 32'(mem_rd_en), 32'(act && m_have));
    if (act && m_have) chk("mem_addr", 32'(mem_addr), 32'(fv * H_ACT + fh));
    chk("mem_bank", 32'(mem_bank), 32'(m_bank));
    chk("frame_ack", 32'(frame_ack), 32'(m_ack));
    chk("have_frame", 32'(have_frame), 32'(m_have));
    dh = disp_h();
    dv = disp_v();
    chk("frame_start", 32'(frame_start), 32'(dh == 0 && dv == 0));
    exp_pix = '0;
    if (n >= LEAD) begin
      k = (n - LEAD) % HIST;
      if (h_act[k]) exp_pix = memf(h_bank[k], dv * H_ACT + dh);
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
      else if (h_bar[k]) exp_pix = vga_pkg::BAR_COLOURS[dh / (H_ACT / 8)];
`endif
    end
    chk("pixel_data", 32'(pixel_data), 32'(exp_pix));
  endtask

  // One clock: advance the model with the inputs that were held during the
  // ending cycle, then check every output in the new cycle.
  task automatic tick();
    logic r, fr;
    int p;
    bit act;
    r  = rst;
    fr = frame_ready;
    @(posedge clk);
    #1;
    if (r) begin
      n = 0; m_bank = 0; m_have = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if ((n % FRAME) == FRAME - 1 && fr) begin
        m_bank = ~m_bank; m_have = 1; m_ack = 1;
      end
      n++;
    end
    p   = n % FRAME;
    act = ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
    h_act[n % HIST]  = act && m_have;
    h_bank[n % HIST] = m_bank;
    h_bar[n % HIST]  = act && !m_have;
    check_all();
  endtask

  task automatic walk_to(input int h, input int v);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (disp_h() == h && disp_v() == v) return;
      tick();
    end
    chk("walk_timeout", 32'(disp_h() * 1000 + disp_v()), 32'(h * 1000 + v));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rd_en"},  32'(mem_rd_en),   32'd0);
    chk({tag, "_addr"},   32'(mem_addr),    32'd0);
    chk({tag, "_bank"},   32'(mem_bank),    32'd0);
    chk({tag, "_ack"},    32'(frame_ack),   32'd0);
    chk({tag, "_pixel"},  32'(pixel_data),  32'd0);
    chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
    chk({tag, "_have"},   32'(have_frame),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", n);
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    bit got;

    // Pixel checkpoints in a bank-1 frame, in display order.
    tbl[0] = '{0,  0, 12'h000};
    tbl[1] = '{15, 0, 12'h00F};
    tbl[2] = '{16, 0, 12'h000};
    tbl[3] = '{0,  1, 12'h010};
    tbl[4] = '{5,  2, 12'h025};
    tbl[5] = '{15, 5, 12'h05F};
    tbl[6] = '{0,  6, 12'h000};

    n = 0;
    rst = 1'b1;
    frame_ready = 1'b0;
    repeat (3) tick();
    chk_reset_values("reset");

    // No frame offered: one full frame of blank output.
    rst = 1'b0;
    repeat (3) tick();
    chk("first_frame_start", 32'(frame_start), 32'd1);
    repeat (FRAME + 10) tick();

    // Offer a frame mid-frame; it must wait for the boundary.
    while ((n % FRAME) != FRAME / 2) tick();
    frame_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      tick();
      if (frame_ack === 1'b1) got = 1;
    end
    chk("swap1_ack", 32'(frame_ack), 32'd1);
    chk("swap1_bank", 32'(mem_bank), 32'd1);
    chk("swap1_rd_en", 32'(mem_rd_en), 32'd1);
    chk("swap1_addr", 32'(mem_addr), 32'd0);
    frame_ready = 1'b0;

    foreach (tbl[i]) begin
      walk_to(tbl[i].dh, tbl[i].dv);
      chk($sformatf("tbl_pix_%0d_%0d", tbl[i].dh, tbl[i].dv), 32'(pixel_data), 32'(tbl[i].pix));
    end

    // frame_ready held one cycle past the ack: exactly one swap.
    while ((n % FRAME) != FRAME / 3) tick();
    frame_ready = 1'b1;
    acks = 0;
    got = 0;
    for (int i = 0; i < 2 * FRAME && !got; i++) begin
      tick();
      if (frame_ack === 1'b1) begin acks++; got = 1; end
    end
    tick();
    if (frame_ack === 1'b1) acks++;
    frame_ready = 1'b0;
    repeat (2 * FRAME) begin
      tick();
      if (frame_ack === 1'b1) acks++;
    end
    chk("single_ack_count", 32'(acks), 32'd1);
    chk("bank_after_single", 32'(mem_bank), 32'd0);

    // Randomised frame_ready activity over several frames.
    repeat (6 * FRAME) begin
      if ($urandom_range(0, 59) == 0) frame_ready = ~frame_ready;
      tick();
    end
    frame_ready = 1'b0;
    repeat (FRAME) tick();

    // Reset in the middle of the active area.
    walk_to(7, 3);
    rst = 1'b1;
    tick();
    chk_reset_values("midrst");
    rst = 1'b0;
    repeat (FRAME + 5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
